// File: rtl/cmd_dispatch_pkg.sv
// Shared types and defaults for the command dispatcher.
// Holds the FSM state encoding, opcode constant and parameter defaults.
package cmd_dispatch_pkg;

    localparam int         CMD_W           = 32;
    localparam int         DEPTH_DEFAULT   = 8;
    localparam int         TIMEOUT_DEFAULT = 4096;
    localparam logic [6:0] OPC_DEFAULT     = 7'b0001011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } state_t;

    function automatic logic opc_match(input logic [CMD_W-1:0] word, input logic [6:0] opc);
        return word[6:0] == opc;
    endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Host write, commit request and commit response handshakes of the dispatcher.
// master = host/commit environment side, slave = dispatcher side.
interface cmd_dispatch_if;
    import cmd_dispatch_pkg::*;

    logic             wr_vaild;
    logic             wr_ready;
    logic [CMD_W-1:0] wr_data;
    logic             req_vaild;
    logic             req_ready;
    logic [CMD_W-1:0] r_out;
    logic             rsp_vaild;
    logic             rsp_ready;

    modport master (
        output wr_vaild, wr_data, req_ready, rsp_vaild,
        input  wr_ready, req_vaild, r_out, rsp_ready
    );

    modport slave (
        input  wr_vaild, wr_data, req_ready, rsp_vaild,
        output wr_ready, req_vaild, r_out, rsp_ready
    );

endinterface

// File: rtl/cmd_fifo.sv
// Power-of-two command FIFO with combinational head read and occupancy count.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    // Storage needs no reset: entries are only read once counted by level.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Pops host commands, filters by opcode, issues one at a time to commit and
// waits for completion with a bounded response timer.
//
// state       | meaning
// ST_IDLE     | nothing outstanding; pops FIFO head when available
// ST_ISSUE    | req_vaild high, holding r_out until req_ready
// ST_WAIT_RSP | rsp_ready high, timing the response
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int         DEPTH   = DEPTH_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [6:0] OPC     = OPC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    cmd_dispatch_if.slave          bus,
    output logic                   bad_op,
    output logic                   timeout,
    output logic [15:0]            done_cnt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   idle
);

    localparam int             TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CMD_W-1:0] r_out_q;
    logic [CMD_W-1:0] r_out_nxt;
    logic             req_vaild_q;
    logic             req_vaild_nxt;
    logic             bad_op_nxt;
    logic             timeout_nxt;
    logic [15:0]      done_cnt_nxt;
    logic [TW-1:0]    wait_cnt;
    logic [TW-1:0]    wait_cnt_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CMD_W-1:0] head;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // wr_ready ignores a same-cycle pop, so a full FIFO never accepts.
    assign push          = bus.wr_vaild && !full;
    assign bus.wr_ready  = !full;
    assign bus.req_vaild = req_vaild_q;
    assign bus.r_out     = r_out_q;
    assign bus.rsp_ready = (state == ST_WAIT_RSP);
    assign idle          = (state == ST_IDLE) && empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            r_out_q     <= '0;
            req_vaild_q <= 1'b0;
            bad_op      <= 1'b0;
            timeout     <= 1'b0;
            done_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            r_out_q     <= r_out_nxt;
            req_vaild_q <= req_vaild_nxt;
            bad_op      <= bad_op_nxt;
            timeout     <= timeout_nxt;
            done_cnt    <= done_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        r_out_nxt     = r_out_q;
        req_vaild_nxt = req_vaild_q;
        bad_op_nxt    = 1'b0;
        timeout_nxt   = 1'b0;
        done_cnt_nxt  = done_cnt;
        wait_cnt_nxt  = '0;
        pop           = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (opc_match(head, OPC)) begin
                        r_out_nxt     = head;
                        req_vaild_nxt = 1'b1;
                        state_nxt     = ST_ISSUE;
                    end else begin
                        bad_op_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.req_ready) begin
                    req_vaild_nxt = 1'b0;
                    state_nxt     = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // Completion is checked first so it wins on the last timer cycle.
                if (bus.rsp_vaild) begin
                    done_cnt_nxt = done_cnt + 16'd1;
                    state_nxt    = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
